// File: rtl/gray_counter_ctrl.sv
// Run controller for the 4-bit gray_counter datapath.
// Turns run/clear buttons and a motion mode into step/up_down/clr strobes.
// It paces steps with a prescaler and keeps a binary shadow of the counter position.
module gray_counter_ctrl #(
  parameter int LIMIT = 1,
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             btn_run,
  input  logic             btn_clr,
  input  logic [1:0]       mode,
  output logic             step,
  output logic             up_down,
  output logic             clr,
  output logic [WIDTH-1:0] position,
  output logic             running
);

  typedef enum logic [1:0] {S_PAUSE, S_RUN, S_CLR} state_t;

  localparam int              PW      = 16;
  localparam logic [PW-1:0]   PS_LAST = PW'(LIMIT - 1);
  localparam logic [WIDTH-1:0] POS_MAX = '1;
  localparam logic [1:0]      M_UP = 2'b00, M_DOWN = 2'b01, M_BOUNCE = 2'b10, M_SINGLE = 2'b11;

  state_t           state, state_n;
  logic [PW-1:0]    presc, presc_n;
  logic             prev_run, prev_clr;
  logic             run_edge, clr_edge;
  logic             due, step_n, dir_eff;
  logic [WIDTH-1:0] pos_n;

  assign run_edge = btn_run & ~prev_run;
  assign clr_edge = btn_clr & ~prev_clr;
  assign due      = (state == S_RUN) && (presc == PS_LAST);

  // Button history; resets high so a button held through reset is not an edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_run <= 1'b1;
      prev_clr <= 1'b1;
    end else begin
      prev_run <= btn_run;
      prev_clr <= btn_clr;
    end
  end

  // State register together with the prescaler phase.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_PAUSE;
      presc <= '0;
    end else begin
      state <= state_n;
      presc <= presc_n;
    end
  end

  // Next state: clear wins, then run/pause toggling; single-step mode never stays in RUN.
  always_comb begin
    state_n = state;
    if (clr_edge) begin
      state_n = S_CLR;
    end else begin
      case (state)
        S_PAUSE: if (run_edge && mode != M_SINGLE) state_n = S_RUN;
        S_RUN:   if (run_edge || mode == M_SINGLE) state_n = S_PAUSE;
        default: state_n = S_PAUSE;
      endcase
    end
  end

  // Step decision, direction and next position; a run edge suppresses a due step.
  always_comb begin
    step_n = 1'b0;
    if (!clr_edge) begin
      if (state == S_PAUSE)    step_n = run_edge && (mode == M_SINGLE);
      else if (state == S_RUN) step_n = due && !run_edge;
    end

    // Prescaler only advances while staying in RUN; any other path parks it at 0.
    presc_n = (state == S_RUN && state_n == S_RUN && !due) ? presc + 1'b1 : '0;

    case (mode)
      M_UP:     dir_eff = 1'b1;
      M_DOWN:   dir_eff = 1'b0;
      M_BOUNCE: dir_eff = (position == POS_MAX) ? 1'b0 :
                          (position == '0)      ? 1'b1 : up_down;
      default:  dir_eff = 1'b1;
    endcase

    pos_n = position;
    if (clr_edge)    pos_n = '0;
    else if (step_n) pos_n = dir_eff ? position + 1'b1 : position - 1'b1;
  end

  // Registered outputs; up_down doubles as the held bounce direction.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      step     <= 1'b0;
      up_down  <= 1'b1;
      clr      <= 1'b0;
      position <= '0;
      running  <= 1'b0;
    end else begin
      step     <= step_n;
      clr      <= clr_edge;
      running  <= (state_n == S_RUN);
      position <= pos_n;
      if (clr_edge)    up_down <= 1'b1;
      else if (step_n) up_down <= dir_eff;
    end
  end

endmodule
